// File: rtl/div_tick_led_flow_pkg.sv
// Shared encodings for the LED flow stage: step modes and bounce direction states.
package div_tick_led_flow_pkg;

    typedef enum logic [1:0] {
        MODE_ROL    = 2'b00,
        MODE_ROR    = 2'b01,
        MODE_BOUNCE = 2'b10,
        MODE_HOLD   = 2'b11
    } mode_e;

    typedef enum logic {
        GO_LEFT  = 1'b0,
        GO_RIGHT = 1'b1
    } bounce_e;

endpackage

// File: rtl/div_tick_led_flow_if.sv
// Signal bundle between the divided-clock source/controls and the LED flow stage.
// No handshake: every signal is a level sampled on each sys_clk rising edge.
interface div_tick_led_flow_if #(
    parameter int LED_W = 4,
    parameter int CNT_W = 3
);
    logic             clk_div_in;
    logic             en;
    logic [1:0]       mode;
    logic [LED_W-1:0] led;
    logic             step_pulse;
    logic [CNT_W-1:0] dbg_tick_cnt;
    logic             dbg_bounce_state;

    modport master (
        output clk_div_in, en, mode,
        input  led, step_pulse, dbg_tick_cnt, dbg_bounce_state
    );

    modport slave (
        input  clk_div_in, en, mode,
        output led, step_pulse, dbg_tick_cnt, dbg_bounce_state
    );
endinterface

// File: rtl/div_tick_led_flow_edge_rise_det.sv
// Rising-edge detector for a slow level signal already in the sys_clk domain.
// The delay register resets high so a signal held high through reset is not seen as an edge.
module edge_rise_det (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic sig,
    output logic rise
);
    logic sig_d1;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sig_d1 <= 1'b1;
        end else begin
            sig_d1 <= sig;
        end
    end

    assign rise = sig & ~sig_d1;
endmodule

// File: rtl/div_tick_led_flow.sv
// Counts rising edges of the divided clock and advances a one-hot LED pattern
// every TICKS_PER_STEP edges: rotate left, rotate right, bounce or hold.
module div_tick_led_flow
    import div_tick_led_flow_pkg::*;
#(
    parameter int LED_W          = 4,
    parameter int TICKS_PER_STEP = 5,
    parameter int CNT_W          = 3
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    div_tick_led_flow_if.slave bus
);
    localparam logic [CNT_W-1:0] LAST_TICK = CNT_W'(TICKS_PER_STEP - 1);
    localparam logic [LED_W-1:0] LED_RESET = LED_W'(1);

    logic             rise;
    logic             step;
    logic [CNT_W-1:0] tick_cnt;
    logic [LED_W-1:0] led_q;
    logic [LED_W-1:0] led_d;
    logic             step_pulse_q;
    bounce_e          state_q;
    bounce_e          state_d;
    mode_e            mode;

    assign mode = mode_e'(bus.mode);

    edge_rise_det u_edge (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .sig       (bus.clk_div_in),
        .rise      (rise)
    );

    // The step is committed on the same edge that samples the rise.
    assign step = bus.en & rise & (tick_cnt == LAST_TICK);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            tick_cnt <= '0;
        end else if (bus.en && rise) begin
            if (tick_cnt == LAST_TICK) begin
                tick_cnt <= '0;
            end else begin
                tick_cnt <= tick_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q      <= GO_LEFT;
            led_q        <= LED_RESET;
            step_pulse_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            led_q        <= led_d;
            step_pulse_q <= step;
        end
    end

    always_comb begin
        led_d   = led_q;
        state_d = (mode == MODE_BOUNCE) ? state_q : GO_LEFT;
        if (step) begin
            case (mode)
                MODE_ROL: led_d = {led_q[LED_W-2:0], led_q[LED_W-1]};
                MODE_ROR: led_d = {led_q[0], led_q[LED_W-1:1]};
                MODE_BOUNCE: begin
                    // Non-rotating shifts; turning at an endpoint moves away from it at once.
                    if (state_q == GO_LEFT) begin
                        if (led_q[LED_W-1]) begin
                            state_d = GO_RIGHT;
                            led_d   = {1'b0, led_q[LED_W-1:1]};
                        end else begin
                            led_d   = {led_q[LED_W-2:0], 1'b0};
                        end
                    end else begin
                        if (led_q[0]) begin
                            state_d = GO_LEFT;
                            led_d   = {led_q[LED_W-2:0], 1'b0};
                        end else begin
                            led_d   = {1'b0, led_q[LED_W-1:1]};
                        end
                    end
                end
                default: led_d = led_q;
            endcase
        end
    end

    assign bus.led              = led_q;
    assign bus.step_pulse       = step_pulse_q;
    assign bus.dbg_tick_cnt     = tick_cnt;
    assign bus.dbg_bounce_state = state_q;
endmodule

// File: tb/tb_div_tick_led_flow.sv
// Bench for div_tick_led_flow: directed scenario table, hand-written corner cases
// and randomized traffic, all checked against a position/direction reference model.
module tb_div_tick_led_flow;
    localparam int LED_W = 4;
    localparam int TPS   = 5;
    localparam int CNT_W = 3;

    logic sys_clk;
    logic sys_rst_n;

    div_tick_led_flow_if #(.LED_W(LED_W), .CNT_W(CNT_W)) bus ();

    div_tick_led_flow #(
        .LED_W          (LED_W),
        .TICKS_PER_STEP (TPS),
        .CNT_W          (CNT_W)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .bus       (bus)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    int n_vec;
    int n_err;
    int cyc;
    int pulse_cnt;
    int first_pulse_cyc;

    // Reference model: lit LED index, bounce direction (0 = left), counted edges.
    int   m_pos;
    bit   m_dir;
    int   m_edges;
    logic m_prev;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_step(input logic [1:0] m);
        case (m)
            2'b00: m_pos = (m_pos + 1) % LED_W;
            2'b01: m_pos = (m_pos + LED_W - 1) % LED_W;
            2'b10: begin
                if (!m_dir) begin
                    if (m_pos == LED_W - 1) begin m_dir = 1'b1; m_pos = m_pos - 1; end
                    else m_pos = m_pos + 1;
                end else begin
                    if (m_pos == 0) begin m_dir = 1'b0; m_pos = m_pos + 1; end
                    else m_pos = m_pos - 1;
                end
            end
            default: ;
        endcase
    endtask

    task automatic do_reset(input logic c);
        @(negedge sys_clk);
        sys_rst_n      = 1'b0;
        bus.clk_div_in = c;
        bus.en         = 1'b1;
        bus.mode       = 2'b00;
        repeat (2) @(posedge sys_clk);
        #1;
        sys_rst_n = 1'b1;
        m_pos = 0; m_dir = 1'b0; m_edges = 0; m_prev = 1'b1;
        cyc = 0; pulse_cnt = 0; first_pulse_cyc = -1;
    endtask

    task automatic cycle(input logic c, input logic e, input logic [1:0] m);
        logic             exp_pulse;
        logic [LED_W-1:0] exp_led;
        @(negedge sys_clk);
        bus.clk_div_in = c;
        bus.en         = e;
        bus.mode       = m;
        @(posedge sys_clk);
        #1;
        cyc++;
        exp_pulse = 1'b0;
        if (e && c && !m_prev) begin
            m_edges++;
            if (m_edges == TPS) begin
                m_edges   = 0;
                exp_pulse = 1'b1;
                model_step(m);
            end
        end
        m_prev = c;
        if (m != 2'b10) m_dir = 1'b0;
        exp_led = LED_W'(1) << m_pos;
        if (bus.step_pulse) begin
            pulse_cnt++;
            if (first_pulse_cyc < 0) first_pulse_cyc = cyc;
        end
        chk("led", 32'(bus.led), 32'(exp_led));
        chk("step_pulse", 32'(bus.step_pulse), 32'(exp_pulse));
        chk("onehot", 32'($onehot(bus.led)), 32'd1);
    endtask

    // One divided-clock period of 6 sys_clk cycles, low half first.
    task automatic period(input logic e, input logic [1:0] m);
        repeat (3) cycle(1'b0, e, m);
        repeat (3) cycle(1'b1, e, m);
    endtask

    typedef struct {
        logic [1:0]       mode;
        int               steps;
        logic [LED_W-1:0] exp_led;
    } vec_t;

    vec_t vt[15];

    initial begin
        n_vec = 0;
        n_err = 0;
        sys_rst_n = 1'b0;
        bus.clk_div_in = 1'b1;
        bus.en = 1'b0;
        bus.mode = 2'b00;

        vt[0]  = '{2'b00, 1, 4'b0010};
        vt[1]  = '{2'b00, 2, 4'b0100};
        vt[2]  = '{2'b00, 3, 4'b1000};
        vt[3]  = '{2'b00, 4, 4'b0001};
        vt[4]  = '{2'b01, 1, 4'b1000};
        vt[5]  = '{2'b01, 2, 4'b0100};
        vt[6]  = '{2'b01, 3, 4'b0010};
        vt[7]  = '{2'b01, 4, 4'b0001};
        vt[8]  = '{2'b10, 1, 4'b0010};
        vt[9]  = '{2'b10, 3, 4'b1000};
        vt[10] = '{2'b10, 4, 4'b0100};
        vt[11] = '{2'b10, 6, 4'b0001};
        vt[12] = '{2'b10, 7, 4'b0010};
        vt[13] = '{2'b10, 8, 4'b0100};
        vt[14] = '{2'b11, 2, 4'b0001};

        // Reset state
        do_reset(1'b0);
        chk("reset_led", 32'(bus.led), 32'h1);
        chk("reset_pulse", 32'(bus.step_pulse), 32'h0);
        chk("reset_tick", 32'(bus.dbg_tick_cnt), 32'h0);
        chk("reset_state", 32'(bus.dbg_bounce_state), 32'h0);

        for (int i = 0; i < 15; i++) begin
            do_reset(1'b0);
            repeat (vt[i].steps * TPS) period(1'b1, vt[i].mode);
            chk($sformatf("table%0d_led", i), 32'(bus.led), 32'(vt[i].exp_led));
            chk($sformatf("table%0d_pulses", i), 32'(pulse_cnt), 32'(vt[i].steps));
            if (i == 0) chk("first_step_latency", 32'(first_pulse_cyc), 32'd28);
        end

        // clk_div_in held high through reset release: no edge counted.
        do_reset(1'b1);
        repeat (3) cycle(1'b1, 1'b1, 2'b00);
        chk("held_high_tick", 32'(bus.dbg_tick_cnt), 32'd0);
        repeat (TPS) period(1'b1, 2'b00);
        chk("held_high_first_step", 32'(first_pulse_cyc), 32'd31);

        // en=0 for three edges while tick_cnt is 2.
        do_reset(1'b0);
        repeat (2) period(1'b1, 2'b00);
        chk("en_pre_tick", 32'(bus.dbg_tick_cnt), 32'd2);
        repeat (3) period(1'b0, 2'b00);
        chk("en_off_tick", 32'(bus.dbg_tick_cnt), 32'd2);
        chk("en_off_pulses", 32'(pulse_cnt), 32'd0);
        repeat (2) period(1'b1, 2'b00);
        chk("en_resume_no_step", 32'(pulse_cnt), 32'd0);
        period(1'b1, 2'b00);
        chk("en_resume_step", 32'(pulse_cnt), 32'd1);

        // Asynchronous reset mid-operation with tick_cnt=3, led=0100.
        do_reset(1'b0);
        repeat (2 * TPS + 3) period(1'b1, 2'b00);
        chk("pre_areset_tick", 32'(bus.dbg_tick_cnt), 32'd3);
        chk("pre_areset_led", 32'(bus.led), 32'h4);
        @(negedge sys_clk);
        #2;
        sys_rst_n = 1'b0;
        #1;
        chk("areset_led", 32'(bus.led), 32'h1);
        chk("areset_tick", 32'(bus.dbg_tick_cnt), 32'd0);
        chk("areset_pulse", 32'(bus.step_pulse), 32'd0);

        // Randomized traffic against the reference model.
        do_reset(1'b0);
        begin
            logic [1:0] m;
            logic       e;
            for (int blk = 0; blk < 60; blk++) begin
                m = 2'($urandom_range(0, 3));
                for (int k = 0; k < 40; k++) begin
                    e = ($urandom_range(0, 9) != 0);
                    cycle(1'($urandom_range(0, 1)), e, m);
                end
            end
            for (int p = 0; p < 40; p++) period(1'b1, 2'($urandom_range(0, 3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
